// File: rtl/tdc_capture.sv
// tdc_capture: digital TDC front end. Captures the DCO ripple count and the
// phase thermometer each reference clock, converts them to an absolute phase
// position in 1/16 DCO-period units and emits the per-cycle phase increment,
// with warm-up qualification and thermometer bubble detection/counting.
module tdc_capture #(
    parameter int unsigned N_WARM = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        tdc_pd,
    input  logic [6:0]  counter_in,
    input  logic [15:0] phase_in,
    output logic [11:0] tdc_word,
    output logic        tdc_valid,
    output logic        bubble_err,
    output logic [7:0]  err_count
);

    localparam logic [2:0] WARM_MAX = 3'(N_WARM);

    // Stage 1 capture registers
    logic [6:0]  cnt_q,      cnt_d;
    logic [15:0] ph_q,       ph_d;
    logic        s1_vld_q,   s1_vld_d;

    // Stage 2 / output registers
    logic [10:0] pos_prev_q, pos_prev_d;
    logic        prev_vld_q, prev_vld_d;
    logic [2:0]  warm_q,     warm_d;
    logic        valid_q,    valid_d;
    logic [11:0] word_q,     word_d;
    logic        bubble_q,   bubble_d;
    logic [7:0]  err_q,      err_d;

    // Stage 2 combinational decode
    logic [4:0]  ones;
    logic [10:0] pos;
    logic [10:0] diff;
    logic        bubble;

    // Decode captured sample: popcount tolerates bubbles; a valid thermometer
    // (0..01..1) has no set bit above a clear bit, i.e. ph & (ph+1) == 0.
    always_comb begin
        ones = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            ones = ones + {4'b0, ph_q[i]};
        end
        pos    = {cnt_q, 4'b0} + {6'b0, ones};
        diff   = pos - pos_prev_q;
        bubble = |(ph_q & (ph_q + 16'd1));
    end

    // Next-state: en freezes everything, tdc_pd clears the pipeline (not
    // err_count), otherwise capture and run the stage-2 update.
    always_comb begin
        cnt_d      = cnt_q;
        ph_d       = ph_q;
        s1_vld_d   = s1_vld_q;
        pos_prev_d = pos_prev_q;
        prev_vld_d = prev_vld_q;
        warm_d     = warm_q;
        valid_d    = valid_q;
        word_d     = word_q;
        bubble_d   = bubble_q;
        err_d      = err_q;

        if (en) begin
            if (tdc_pd) begin
                s1_vld_d   = 1'b0;
                prev_vld_d = 1'b0;
                warm_d     = '0;
                valid_d    = 1'b0;
                word_d     = '0;
                bubble_d   = 1'b0;
            end else begin
                cnt_d    = counter_in;
                ph_d     = phase_in;
                s1_vld_d = 1'b1;
                // bubble_err is a one-enabled-cycle pulse
                bubble_d = 1'b0;
                if (s1_vld_q) begin
                    bubble_d = bubble;
                    if (bubble && (err_q != 8'hFF)) begin
                        err_d = err_q + 8'd1;
                    end
                    pos_prev_d = pos;
                    prev_vld_d = 1'b1;
                    if (prev_vld_q) begin
                        if (warm_q < WARM_MAX) begin
                            warm_d = warm_q + 3'd1;
                        end
                        if (warm_d == WARM_MAX) begin
                            valid_d = 1'b1;
                        end
                        word_d = valid_d ? {1'b0, diff} : '0;
                    end
                end
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            ph_q       <= '0;
            s1_vld_q   <= 1'b0;
            pos_prev_q <= '0;
            prev_vld_q <= 1'b0;
            warm_q     <= '0;
            valid_q    <= 1'b0;
            word_q     <= '0;
            bubble_q   <= 1'b0;
            err_q      <= '0;
        end else begin
            cnt_q      <= cnt_d;
            ph_q       <= ph_d;
            s1_vld_q   <= s1_vld_d;
            pos_prev_q <= pos_prev_d;
            prev_vld_q <= prev_vld_d;
            warm_q     <= warm_d;
            valid_q    <= valid_d;
            word_q     <= word_d;
            bubble_q   <= bubble_d;
            err_q      <= err_d;
        end
    end

    assign tdc_word   = word_q;
    assign tdc_valid  = valid_q;
    assign bubble_err = bubble_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_tdc_capture.sv
// Directed self-checking bench for tdc_capture (N_WARM = 4).
module tb_tdc_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        tdc_pd;
    logic [6:0]  counter_in;
    logic [15:0] phase_in;
    logic [11:0] tdc_word;
    logic        tdc_valid;
    logic        bubble_err;
    logic [7:0]  err_count;

    int total = 0;
    int bad   = 0;
    logic [6:0] c;

    tdc_capture #(.N_WARM(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .tdc_pd     (tdc_pd),
        .counter_in (counter_in),
        .phase_in   (phase_in),
        .tdc_word   (tdc_word),
        .tdc_valid  (tdc_valid),
        .bubble_err (bubble_err),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    // Apply one sample, clock it in, and settle 1 time unit after the edge
    task automatic drive(input logic [6:0] cnt, input logic [15:0] ph);
        counter_in = cnt;
        phase_in   = ph;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; tdc_pd = 1'b0; counter_in = '0; phase_in = '0;
        #3;
        total++; if (tdc_word !== 12'd0) begin bad++; $display("FAIL reset_word got=%0d exp=0", tdc_word); end
        total++; if (tdc_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", tdc_valid); end
        total++; if (bubble_err !== 1'b0) begin bad++; $display("FAIL reset_bubble got=%b exp=0", bubble_err); end
        total++; if (err_count !== 8'd0) begin bad++; $display("FAIL reset_err got=%0d exp=0", err_count); end
        @(posedge clk); #1;
        rst = 1'b0; en = 1'b1;
    endtask

    // Warm-up from E0 with +40 steps, 8 ones: valid rises after E5, word 640
    task automatic test_steady_lock(input string tag, input logic [7:0] exp_err);
        c = 7'd0;
        for (int i = 0; i < 8; i++) begin
            drive(c, 16'h00FF);
            c = c + 7'd40;
            total++;
            if (tdc_valid !== (i >= 5)) begin
                bad++; $display("FAIL %s_valid E%0d got=%b exp=%b", tag, i, tdc_valid, (i >= 5));
            end
            total++;
            if (tdc_word !== ((i >= 5) ? 12'd640 : 12'd0)) begin
                bad++; $display("FAIL %s_word E%0d got=%0d exp=%0d", tag, i, tdc_word, (i >= 5) ? 640 : 0);
            end
            total++;
            if (bubble_err !== 1'b0) begin bad++; $display("FAIL %s_bubble E%0d got=%b exp=0", tag, i, bubble_err); end
        end
        total++;
        if (err_count !== exp_err) begin bad++; $display("FAIL %s_err got=%0d exp=%0d", tag, err_count, exp_err); end
    endtask

    // 120/8 ones (1928) -> 32/3 ones (515): (515-1928) mod 2048 = 635
    task automatic test_counter_wrap();
        drive(7'd120, 16'h00FF);
        drive(7'd32, 16'h0007);
        drive(7'd32, 16'h0007);
        total++; if (tdc_word !== 12'd635) begin bad++; $display("FAIL wrap_word got=%0d exp=635", tdc_word); end
        drive(7'd32, 16'h0007);
        total++; if (tdc_word !== 12'd0) begin bad++; $display("FAIL wrap_zero got=%0d exp=0", tdc_word); end
    endtask

    // 10/16 ones = 176, 11/0 ones = 176 -> 0; 13/4 ones = 212 -> 36
    task automatic test_full_therm();
        drive(7'd10, 16'hFFFF);
        drive(7'd11, 16'h0000);
        drive(7'd13, 16'h000F);
        total++; if (tdc_word !== 12'd0) begin bad++; $display("FAIL full_carry got=%0d exp=0", tdc_word); end
        drive(7'd13, 16'h000F);
        total++; if (tdc_word !== 12'd36) begin bad++; $display("FAIL full_next got=%0d exp=36", tdc_word); end
    endtask

    // 00F7 uses 7 ones: 328 -> 327 gives 2047, back to 328 gives 1
    task automatic test_bubble();
        drive(7'd20, 16'h00FF);
        drive(7'd20, 16'h00F7);
        total++; if (bubble_err !== 1'b0) begin bad++; $display("FAIL bub_pre got=%b exp=0", bubble_err); end
        drive(7'd20, 16'h00FF);
        total++; if (bubble_err !== 1'b1) begin bad++; $display("FAIL bub_flag got=%b exp=1", bubble_err); end
        total++; if (err_count !== 8'd1) begin bad++; $display("FAIL bub_cnt got=%0d exp=1", err_count); end
        total++; if (tdc_word !== 12'd2047) begin bad++; $display("FAIL bub_word got=%0d exp=2047", tdc_word); end
        drive(7'd20, 16'h00FF);
        total++; if (bubble_err !== 1'b0) begin bad++; $display("FAIL bub_pulse got=%b exp=0", bubble_err); end
        total++; if (tdc_word !== 12'd1) begin bad++; $display("FAIL bub_word2 got=%0d exp=1", tdc_word); end
        for (int i = 0; i < 100; i++) drive(7'd20, 16'h00F7);
        drive(7'd20, 16'h00FF);
        total++; if (err_count !== 8'd101) begin bad++; $display("FAIL bub_cnt101 got=%0d exp=101", err_count); end
        for (int i = 0; i < 200; i++) drive(7'd20, 16'h00F7);
        drive(7'd20, 16'h00FF);
        drive(7'd20, 16'h00FF);
        total++; if (err_count !== 8'd255) begin bad++; $display("FAIL bub_sat got=%0d exp=255", err_count); end
        total++; if (bubble_err !== 1'b0) begin bad++; $display("FAIL bub_sat_flag got=%b exp=0", bubble_err); end
    endtask

    task automatic test_pd();
        tdc_pd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(7'd20, 16'h00F7);
            total++; if (tdc_word !== 12'd0) begin bad++; $display("FAIL pd_word %0d got=%0d exp=0", i, tdc_word); end
            total++; if (tdc_valid !== 1'b0) begin bad++; $display("FAIL pd_valid %0d got=%b exp=0", i, tdc_valid); end
            total++; if (bubble_err !== 1'b0) begin bad++; $display("FAIL pd_bubble %0d got=%b exp=0", i, bubble_err); end
            total++; if (err_count !== 8'd255) begin bad++; $display("FAIL pd_err %0d got=%0d exp=255", i, err_count); end
        end
        tdc_pd = 1'b0;
        test_steady_lock("pdwarm", 8'd255);
    endtask

    // c continues the +40 sequence left by the previous warm-up
    task automatic test_en();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(7'(c + 7'd3 * 7'(i) + 7'd1), 16'h0F0F);
            total++; if (tdc_word !== 12'd640) begin bad++; $display("FAIL en_word %0d got=%0d exp=640", i, tdc_word); end
            total++; if (tdc_valid !== 1'b1) begin bad++; $display("FAIL en_valid %0d got=%b exp=1", i, tdc_valid); end
            total++; if (bubble_err !== 1'b0) begin bad++; $display("FAIL en_bubble %0d got=%b exp=0", i, bubble_err); end
        end
        en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(c, 16'h00FF); c = c + 7'd40;
            total++; if (tdc_word !== 12'd640) begin bad++; $display("FAIL en_resume %0d got=%0d exp=640", i, tdc_word); end
        end
        // Bubble sample, then freeze while bubble_err is high
        drive(c, 16'h00F7); c = c + 7'd40;
        drive(c, 16'h00FF); c = c + 7'd40;
        total++; if (bubble_err !== 1'b1) begin bad++; $display("FAIL enb_flag got=%b exp=1", bubble_err); end
        total++; if (tdc_word !== 12'd639) begin bad++; $display("FAIL enb_word got=%0d exp=639", tdc_word); end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(7'(c + 7'd5), 16'h00F7);
            total++; if (bubble_err !== 1'b1) begin bad++; $display("FAIL enb_hold %0d got=%b exp=1", i, bubble_err); end
            total++; if (tdc_word !== 12'd639) begin bad++; $display("FAIL enb_word_hold %0d got=%0d exp=639", i, tdc_word); end
        end
        en = 1'b1;
        drive(c, 16'h00FF); c = c + 7'd40;
        total++; if (bubble_err !== 1'b0) begin bad++; $display("FAIL enb_clear got=%b exp=0", bubble_err); end
        total++; if (tdc_word !== 12'd641) begin bad++; $display("FAIL enb_word641 got=%0d exp=641", tdc_word); end
        drive(c, 16'h00FF); c = c + 7'd40;
        total++; if (tdc_word !== 12'd640) begin bad++; $display("FAIL enb_word640 got=%0d exp=640", tdc_word); end
    endtask

    task automatic test_reset_mid();
        total++; if (tdc_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre got=%b exp=1", tdc_valid); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (tdc_word !== 12'd0) begin bad++; $display("FAIL rmid_word got=%0d exp=0", tdc_word); end
        total++; if (tdc_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", tdc_valid); end
        total++; if (bubble_err !== 1'b0) begin bad++; $display("FAIL rmid_bubble got=%b exp=0", bubble_err); end
        total++; if (err_count !== 8'd0) begin bad++; $display("FAIL rmid_err got=%0d exp=0", err_count); end
        @(posedge clk); #1;
        rst = 1'b0;
        test_steady_lock("rwarm", 8'd0);
    endtask

    initial begin
        test_reset();
        test_steady_lock("lock", 8'd0);
        test_counter_wrap();
        test_full_therm();
        test_bubble();
        test_pd();
        test_en();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdc_capture.md
# tdc_capture

Digital front end of the TDC that sits directly upstream of the ADPLL controller. Each reference clock it captures the 7-bit DCO ripple count and the 16-tap phase thermometer from the analog TDC. It converts them into an absolute DCO phase position and outputs the per-reference-cycle phase increment as a 12-bit `tdc_word` (LSB = 1/16 DCO period). It also provides warm-up qualification and thermometer bubble detection/counting.

## Interface
- `N_WARM`, 4: number of computed differences before `tdc_valid` asserts; legal range 1..7.
- `clk` input 1: reference clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: synchronous enable; when 0, every register holds.
- `tdc_pd` input 1: TDC power-down; synchronous pipeline clear while 1 (when `en`=1).
- `counter_in` input 7: DCO ripple counter, free-running mod 128.
- `phase_in` input 16: phase thermometer; bit 0 = first tap, ones fill from LSB.
- `tdc_word` output 12: phase increment, unsigned, bit 11 always 0.
- `tdc_valid` output 1: `tdc_word` qualified.
- `bubble_err` output 1: one-cycle flag; the sample behind the current `tdc_word` update had a non-thermometer code.
- `err_count` output 8: saturating count of bubble events.

## Operation
- Stage 1 (capture): `cnt_q <= counter_in`, `ph_q <= phase_in`. Sets `s1_vld`.
- Stage 2 (position):
  - `ones` = popcount(`ph_q`), range 0..16. Popcount is used so the decode tolerates bubbles.
  - `pos` = ({`cnt_q`,4'b0} + `ones`) mod 2048, 11 bits. Sixteen ones therefore carries into the count field.
- Bubble:
  - A code is a bubble when some bit i=1 has a bit j<i with j=0 (the code is not of form 0…01…1).
  - Evaluated on `ph_q` in stage 2 when `s1_vld`=1.
- Difference:
  - When `s1_vld` and `prev_vld` are both 1: `diff` = (`pos` − `pos_prev`) mod 2048.
  - `pos_prev <= pos` and `prev_vld <= 1` on every stage-2 update.
- Warm-up counter `warm` (3 bits):
  - Increments on each computed difference, saturating at `N_WARM`.
  - On the update where `warm` reaches `N_WARM`, `tdc_valid <= 1`.
- Output:
  - `tdc_word <= {1'b0,diff}` only when `tdc_valid` is (or becomes) 1.
  - Otherwise `tdc_word` holds 0.
- `err_count` increments on each bubble, saturating at 255. It is cleared only by `rst`.
- `tdc_pd`=1 with `en`=1 clears `s1_vld`, `prev_vld`, `warm`, `tdc_valid`, `tdc_word`, and `bubble_err` to 0. `err_count` is kept. Capture is suppressed while `tdc_pd`=1.
- `en`=0 freezes all state, including the `bubble_err` level. `en` has priority below `rst` and above `tdc_pd`.

## Timing
- Reset values: `tdc_word`=0, `tdc_valid`=0, `bubble_err`=0, `err_count`=0. All internal valids, `warm`, `pos_prev`, `cnt_q`, and `ph_q` are 0.
- Latency: a sample captured at edge k produces its `pos` at edge k+1. The `tdc_word` for samples k−1→k appears after edge k+1, stable for the consumer's falling-edge sampling.
- From the first capture edge E0 (first edge with `en`=1, `tdc_pd`=0 after reset or power-up):
  - First difference at E2.
  - `tdc_valid` rises after edge E(N_WARM+1), together with the first nonzero `tdc_word`.
- `bubble_err` is aligned with the stage-2 update of the offending sample. It lasts exactly one enabled cycle.
- Mid-operation reset: immediate asynchronous return to reset values. The full warm-up is required again.
- Simultaneous `tdc_pd` release and bubble on the first capture: the bubble is flagged at E1 even though no difference exists yet.

## Test plan
- Reset: assert `rst` mid-stream with `tdc_valid`=1 → all outputs 0 immediately. `err_count`=0.
- Steady lock: `counter_in` steps +40 per edge, `phase_in`=16'h00FF → `tdc_valid` rises after E5 (N_WARM=4). `tdc_word`=640 every cycle after that; `bubble_err` stays 0.
- Counter wrap: `counter_in` 120→32 with phase ones 8→3 (16'h00FF→16'h0007) → `tdc_word`=635.
- Full thermometer: cnt=10 with 16'hFFFF, then cnt=11 with 16'h0000 → `pos` 176 both → `tdc_word`=0. Next, cnt=13 with 16'h000F → 36.
- Bubble: inject 16'h00F7 → single-cycle `bubble_err`=1, `ones`=7 used, `err_count`+1. Force 300 bubbles → `err_count`=255.
- `tdc_pd`/`en`:
  - Assert `tdc_pd` for 3 edges → `tdc_word`=0 and `tdc_valid`=0 at the next edge. After release, warm-up takes N_WARM+1 edges again; `err_count` is unchanged.
  - Hold `en`=0 for 5 edges with a changing counter → outputs frozen.
